inv_sub_bytes_seq: RTL

Sequential AES InvSubBytes engine for the decryption datapath.
- Accepts a full 128-bit state over a valid/ready handshake.
- Applies the inverse S-box to each byte in turn: first the inverse affine transform, then the GF(2^8) multiplicative inverse, computed iteratively as x^254 by square-and-multiply.
- Presents the transformed state on an output valid/ready handshake.
- Needs no lookup table and no 256-way parallel inverse search, so it is the area-lean decrypt-side counterpart of the forward S-box path.

---
 rtl/inv_sub_bytes_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: one byte at a time, inverse affine followed by a
// GF(2^8) inverse computed as x^254 with seven square-and-multiply steps.
module inv_sub_bytes_seq #(
  parameter int NUM_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_state,
  output logic                   busy
);

  localparam int W     = 8 * NUM_BYTES;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, EXP, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     buf_q, buf_d;
  logic [W-1:0]     res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nx;
  logic [2:0]       step_q, step_d;
  logic [7:0]       sq_q, sq_d, acc_q, acc_d;
  logic [7:0]       sq_sq, acc_mul;
  logic             accept, last_step, last_byte;

  // Carry-less 8x8 product folded back modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({7'b0, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ ({6'b0, 9'h11B} << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[i] = s[3'(i + 2)] ^ s[3'(i + 5)] ^ s[3'(i + 7)];
    return b ^ 8'h05;
  endfunction

  assign accept    = in_valid & in_ready;
  assign last_step = (step_q == 3'd6);
  assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));
  assign idx_nx    = idx_q + IDX_W'(1);
  assign sq_sq     = gf_mul(sq_q, sq_q);
  // acc picks up sq^2 each step: x^2 * x^4 * ... * x^128 = x^254.
  assign acc_mul   = gf_mul(acc_q, sq_sq);
  assign out_state = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXP;
      EXP:     if (last_step && last_byte) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    buf_d  = buf_q;
    res_d  = res_q;
    idx_d  = idx_q;
    step_d = step_q;
    sq_d   = sq_q;
    acc_d  = acc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          buf_d  = in_state;
          idx_d  = '0;
          step_d = 3'd0;
          sq_d   = inv_affine(in_state[7:0]);
          acc_d  = 8'h01;
        end
      end
      EXP: begin
        sq_d  = sq_sq;
        acc_d = acc_mul;
        if (last_step) begin
          res_d[{idx_q, 3'b000} +: 8] = acc_mul;
          if (!last_byte) begin
            idx_d  = idx_nx;
            step_d = 3'd0;
            sq_d   = inv_affine(buf_q[{idx_nx, 3'b000} +: 8]);
            acc_d  = 8'h01;
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Input buffer is pure data and only meaningful after a capture.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      idx_q  <= '0;
      step_q <= 3'd0;
      sq_q   <= 8'h00;
      acc_q  <= 8'h00;
    end else begin
      res_q  <= res_d;
      idx_q  <= idx_d;
      step_q <= step_d;
      sq_q   <= sq_d;
      acc_q  <= acc_d;
    end
  end

endmodule
